// File: rtl/btle_rx_pdu_reader.sv
// Streams a status octet plus the RX PDU octets read from PHY memory after each decode_end.
// Optional feature macro: BTLE_RX_PDU_READER_CRC_DROP_EN (suppress frames with a bad CRC).
module btle_rx_pdu_reader #(
    parameter int unsigned MEM_ADDR_BIT_WIDTH = 6,
    parameter int unsigned PDU_HEADER_OCTETS  = 2,
    parameter int unsigned DROP_CNT_BIT_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_decode_end,
    input  logic                          rx_crc_ok,
    input  logic [6:0]                    rx_payload_length,
    output logic [MEM_ADDR_BIT_WIDTH-1:0] rx_pdu_octet_mem_addr,
    input  logic [7:0]                    rx_pdu_octet_mem_data,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    output logic                          m_last,
    input  logic                          m_ready,
    output logic                          busy,
    output logic [DROP_CNT_BIT_WIDTH-1:0] drop_count
);

    localparam int unsigned W     = MEM_ADDR_BIT_WIDTH;
    localparam int unsigned D     = DROP_CNT_BIT_WIDTH;
    localparam int unsigned CW    = W + 1;
    localparam int unsigned DEPTH = 1 << W;
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW-1:0] TWO = CW'(2);

    typedef enum logic [1:0] {StIdle, StStatus, StStream} state_e;

    state_e        state_q;
    logic [CW-1:0] n_q;      // octets to read from memory
    logic [CW-1:0] iss_q;    // reads issued so far, including the one presented this cycle
    logic [CW-1:0] ld_q;     // memory octets loaded into the output register
    logic          req_q;    // address presented this cycle is a real read
    logic          pend_q;   // read data for last cycle's address arrives this cycle
    logic [7:0]    fifo_q [2];
    logic [1:0]    cnt_q;

    logic [7:0]    len_sum;
    logic          snap_trunc;
    logic [CW-1:0] snap_n;
    logic          start, ignore, out_accept, out_free, load, req_d;
    logic [7:0]    src_data;
    logic [7:0]    fifo_d [2];
    logic [1:0]    cnt_d;

    assign len_sum    = {1'b0, rx_payload_length} + 8'(PDU_HEADER_OCTETS);
    assign snap_trunc = {24'b0, len_sum} > DEPTH;
    assign snap_n     = snap_trunc ? CW'(DEPTH) : CW'(len_sum);

`ifdef BTLE_RX_PDU_READER_CRC_DROP_EN
    assign start = (state_q == StIdle) && rx_decode_end && rx_crc_ok;
`else
    assign start = (state_q == StIdle) && rx_decode_end;
`endif
    assign ignore     = rx_decode_end && (state_q != StIdle);
    assign out_accept = m_valid && m_ready;
    assign out_free   = !m_valid || m_ready;
    assign src_data   = (cnt_q != 2'd0) ? fifo_q[0] : rx_pdu_octet_mem_data;
    assign load       = (state_q != StIdle) && out_free && (ld_q != n_q) &&
                        ((cnt_q != 2'd0) || pend_q);

    // Prefetch FIFO: arriving read data is pushed unless it bypasses straight to the output.
    // Reads are throttled so buffered + in-flight octets never exceed two.
    always_comb begin
        fifo_d = fifo_q;
        cnt_d  = cnt_q;
        if (load && cnt_q != 2'd0) begin
            fifo_d[0] = fifo_q[1];
            cnt_d     = cnt_q - 2'd1;
        end
        if (pend_q && !(load && cnt_q == 2'd0)) begin
            fifo_d[cnt_d[0]] = rx_pdu_octet_mem_data;
            cnt_d            = cnt_d + 2'd1;
        end
        req_d = (iss_q != n_q) && ((3'(cnt_d) + 3'(req_q)) <= 3'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q               <= StIdle;
            n_q                   <= '0;
            iss_q                 <= '0;
            ld_q                  <= '0;
            req_q                 <= 1'b0;
            pend_q                <= 1'b0;
            fifo_q[0]             <= '0;
            fifo_q[1]             <= '0;
            cnt_q                 <= '0;
            rx_pdu_octet_mem_addr <= '0;
            m_data                <= '0;
            m_valid               <= 1'b0;
            m_last                <= 1'b0;
            busy                  <= 1'b0;
            drop_count            <= '0;
        end else begin
            if (ignore && drop_count != {D{1'b1}}) begin
                drop_count <= drop_count + D'(1);
            end
            fifo_q[0] <= fifo_d[0];
            fifo_q[1] <= fifo_d[1];
            cnt_q     <= cnt_d;
            pend_q    <= req_q;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        // Address 0 is already on the bus while idle, so that read counts now.
                        state_q               <= StStatus;
                        busy                  <= 1'b1;
                        m_valid               <= 1'b1;
                        m_data                <= {rx_crc_ok, snap_trunc, 6'b0};
                        m_last                <= (snap_n == '0);
                        n_q                   <= snap_n;
                        ld_q                  <= '0;
                        cnt_q                 <= '0;
                        pend_q                <= (snap_n != '0);
                        req_q                 <= (snap_n >= TWO);
                        rx_pdu_octet_mem_addr <= (snap_n >= TWO) ? W'(1) : '0;
                        iss_q                 <= (snap_n >= TWO) ? TWO :
                                                 ((snap_n != '0) ? ONE : '0);
                    end
                end
                StStatus, StStream: begin
                    if (out_accept && m_last) begin
                        state_q               <= StIdle;
                        busy                  <= 1'b0;
                        m_valid               <= 1'b0;
                        m_last                <= 1'b0;
                        req_q                 <= 1'b0;
                        pend_q                <= 1'b0;
                        cnt_q                 <= '0;
                        iss_q                 <= '0;
                        rx_pdu_octet_mem_addr <= '0;
                    end else begin
                        if (state_q == StStatus && out_accept) begin
                            state_q <= StStream;
                        end
                        if (load) begin
                            m_valid <= 1'b1;
                            m_data  <= src_data;
                            m_last  <= ((ld_q + ONE) == n_q);
                            ld_q    <= ld_q + ONE;
                        end else if (out_accept) begin
                            m_valid <= 1'b0;
                        end
                        if (req_d) begin
                            rx_pdu_octet_mem_addr <= iss_q[W-1:0];
                            iss_q                 <= iss_q + ONE;
                        end
                        req_q <= req_d;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_btle_rx_pdu_reader.sv
// Randomised bench for btle_rx_pdu_reader: a synchronous-read memory model feeds the DUT and
// captured frames are compared with frames derived from the memory contents and length rules.
module tb_btle_rx_pdu_reader;

    localparam int DEPTH = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_decode_end = 1'b0;
    logic       rx_crc_ok = 1'b0;
    logic [6:0] rx_payload_length = '0;
    logic [5:0] addr;
    logic [7:0] mem_data;
    logic [7:0] m_data;
    logic       m_valid, m_last;
    logic       m_ready = 1'b0;
    logic       busy;
    logic [7:0] drop_count;

    logic [7:0] mem [DEPTH];

    btle_rx_pdu_reader dut (
        .clk                   (clk),
        .rst                   (rst),
        .rx_decode_end         (rx_decode_end),
        .rx_crc_ok             (rx_crc_ok),
        .rx_payload_length     (rx_payload_length),
        .rx_pdu_octet_mem_addr (addr),
        .rx_pdu_octet_mem_data (mem_data),
        .m_data                (m_data),
        .m_valid               (m_valid),
        .m_last                (m_last),
        .m_ready               (m_ready),
        .busy                  (busy),
        .drop_count            (drop_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) mem_data <= mem[addr];

    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit         last_q[$];
    int         acc_cyc[$];
    int         stable_err;
    bit         busy0, busy_seen, timed_out;
    int         drop_exp = 0;

    function automatic void build_exp(input bit crc, input int plen);
        int len = plen + 2;
        int n = (len > DEPTH) ? DEPTH : len;
        exp_q.delete();
`ifdef BTLE_RX_PDU_READER_CRC_DROP_EN
        if (!crc) return;
`endif
        exp_q.push_back({crc, (len > DEPTH) ? 1'b1 : 1'b0, 6'b0});
        for (int i = 0; i < n; i++) exp_q.push_back(mem[i]);
    endfunction

    function automatic int frame_errs();
        int e = (got_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) e++;
            if (last_q[i] != (i == exp_q.size() - 1)) e++;
        end
        return e;
    endfunction

    function automatic int timing_errs();
        int e = 0;
        for (int j = 0; j < acc_cyc.size(); j++) if (acc_cyc[j] != j + 1) e++;
        return e;
    endfunction

    task automatic fill_mem(input bit ramp);
        for (int i = 0; i < DEPTH; i++) mem[i] = ramp ? 8'(i + 'h10) : 8'($urandom);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        rx_decode_end = 1'b0;
        m_ready = 1'b0;
    endtask

    // Pulses decode_end in the first driven cycle and collects accepted octets.
    // mode: 0 ready held high, 1 ready toggling, 2 random ready.
    task automatic run_frame(input bit crc, input int plen, input int mode, input int extra_at,
                             input int budget);
        bit         pstall = 1'b0;
        logic [7:0] pdata = '0;
        logic       plast = 1'b0;
        got_q.delete(); last_q.delete(); acc_cyc.delete();
        stable_err = 0; timed_out = 1'b1; busy0 = 1'b1; busy_seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            rx_decode_end     = (i == 0) || (i == extra_at);
            rx_crc_ok         = (i == 0) ? crc : 1'($urandom);
            rx_payload_length = (i == 0) ? 7'(plen) : 7'($urandom);
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (i % 2 == 1);
                default: m_ready = ($urandom_range(9, 0) < 7);
            endcase
            @(negedge clk);
            if (i == 0) busy0 = busy;
            if (busy) busy_seen = 1'b1;
            if (pstall && !(m_valid && m_data == pdata && m_last == plast)) stable_err++;
            pstall = m_valid && !m_ready;
            pdata  = m_data;
            plast  = m_last;
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                last_q.push_back(m_last);
                acc_cyc.push_back(i);
                if (m_last) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", m_valid); else pass_cnt++;
        total_cnt++; if (m_last !== 1'b0) $display("FAIL rst_last: got %b want 0", m_last); else pass_cnt++;
        total_cnt++; if (m_data !== 8'h00) $display("FAIL rst_data: got %h want 00", m_data); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (drop_count !== 8'h00) $display("FAIL rst_drop: got %h want 00", drop_count); else pass_cnt++;
        total_cnt++; if (addr !== 6'd0) $display("FAIL rst_addr: got %0d want 0", addr); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_zero_wait();
        for (int k = 0; k < 5; k++) begin
            bit crc;
            int plen;
            fill_mem(k == 0);
`ifdef BTLE_RX_PDU_READER_CRC_DROP_EN
            crc = 1'b1;
`else
            crc = (k == 0) ? 1'b1 : 1'($urandom);
`endif
            plen = (k == 0) ? 4 : int'($urandom_range(127, 0));
            build_exp(crc, plen);
            run_frame(crc, plen, 0, -1, 200);
            total_cnt++; if (frame_errs() !== 0) $display("FAIL zw_frame%0d: %0d errors want 0", k, frame_errs()); else pass_cnt++;
            total_cnt++; if (timing_errs() !== 0 || timed_out) $display("FAIL zw_timing%0d: %0d late octets (timeout %b) want 0", k, timing_errs(), timed_out); else pass_cnt++;
            total_cnt++; if (busy0 !== 1'b0) $display("FAIL zw_busy_pre%0d: got %b want 0", k, busy0); else pass_cnt++;
            idle_cycle();
            @(negedge clk);
            total_cnt++; if (busy !== 1'b0 || m_valid !== 1'b0) $display("FAIL zw_idle%0d: busy %b valid %b want 0 0", k, busy, m_valid); else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 4; k++) begin
            int plen = (k == 0) ? 4 : int'($urandom_range(127, 0));
            fill_mem(k == 0);
            build_exp(1'b1, plen);
            run_frame(1'b1, plen, (k == 0) ? 1 : 2, -1, 600);
            total_cnt++; if (frame_errs() !== 0 || timed_out) $display("FAIL bp_frame%0d: %0d errors (timeout %b) want 0", k, frame_errs(), timed_out); else pass_cnt++;
            total_cnt++; if (stable_err !== 0) $display("FAIL bp_stable%0d: %0d unstable stalls want 0", k, stable_err); else pass_cnt++;
            idle_cycle();
        end
    endtask

    task automatic test_truncation();
        for (int k = 0; k < 3; k++) begin
            int plen = (k == 0) ? 70 : int'($urandom_range(127, 61));
            fill_mem(1'b0);
            build_exp(1'b1, plen);
            run_frame(1'b1, plen, (k == 0) ? 0 : 2, -1, 600);
            total_cnt++; if (frame_errs() !== 0 || timed_out) $display("FAIL tr_frame%0d: %0d errors (timeout %b) want 0", k, frame_errs(), timed_out); else pass_cnt++;
            if (k == 0) begin
                total_cnt++; if (got_q.size() !== 65) $display("FAIL tr_count: got %0d want 65", got_q.size()); else pass_cnt++;
                total_cnt++; if (got_q.size() == 0 || got_q[0] !== 8'hC0) $display("FAIL tr_status: got %h want c0", (got_q.size() == 0) ? 8'hxx : got_q[0]); else pass_cnt++;
            end
            idle_cycle();
        end
    endtask

    task automatic test_back_to_back();
        fill_mem(1'b0);
        build_exp(1'b1, 10);
        run_frame(1'b1, 10, 0, -1, 200);
        total_cnt++; if (frame_errs() !== 0 || timed_out) $display("FAIL b2b_first: %0d errors want 0", frame_errs()); else pass_cnt++;
        build_exp(1'b1, 5);
        run_frame(1'b1, 5, 0, -1, 200);
        total_cnt++; if (busy0 !== 1'b0) $display("FAIL b2b_idle: busy %b want 0", busy0); else pass_cnt++;
        total_cnt++; if (frame_errs() !== 0 || timed_out) $display("FAIL b2b_second: %0d errors want 0", frame_errs()); else pass_cnt++;
        total_cnt++; if (timing_errs() !== 0) $display("FAIL b2b_timing: %0d late octets want 0", timing_errs()); else pass_cnt++;
        idle_cycle();
    endtask

    task automatic test_crc_bad();
        fill_mem(1'b1);
        build_exp(1'b0, 0);
        run_frame(1'b0, 0, 0, -1, 20);
`ifdef BTLE_RX_PDU_READER_CRC_DROP_EN
        total_cnt++; if (got_q.size() !== 0) $display("FAIL crc_drop_count: got %0d want 0", got_q.size()); else pass_cnt++;
        total_cnt++; if (busy_seen !== 1'b0) $display("FAIL crc_drop_busy: got %b want 0", busy_seen); else pass_cnt++;
`else
        total_cnt++; if (frame_errs() !== 0 || timed_out) $display("FAIL crc_bad_frame: %0d errors want 0", frame_errs()); else pass_cnt++;
        total_cnt++; if (got_q.size() !== 3) $display("FAIL crc_bad_count: got %0d want 3", got_q.size()); else pass_cnt++;
`endif
        idle_cycle();
        @(negedge clk);
        total_cnt++; if (drop_count !== 8'(drop_exp)) $display("FAIL crc_bad_drop: got %0d want %0d", drop_count, drop_exp); else pass_cnt++;
    endtask

    task automatic test_drop();
        fill_mem(1'b0);
        build_exp(1'b1, 20);
        run_frame(1'b1, 20, 0, 3, 200);
        drop_exp = (drop_exp < 255) ? drop_exp + 1 : 255;
        total_cnt++; if (frame_errs() !== 0 || timed_out) $display("FAIL drop_frame: %0d errors want 0", frame_errs()); else pass_cnt++;
        idle_cycle();
        @(negedge clk);
        total_cnt++; if (drop_count !== 8'(drop_exp)) $display("FAIL drop_one: got %0d want %0d", drop_count, drop_exp); else pass_cnt++;

        // Hold a long frame stalled while hammering decode_end to saturate the counter.
        fill_mem(1'b0);
        build_exp(1'b1, 127);
        @(posedge clk); #1;
        rx_decode_end = 1'b1; rx_crc_ok = 1'b1; rx_payload_length = 7'd127; m_ready = 1'b0;
        for (int i = 0; i < 260; i++) begin
            @(posedge clk); #1;
            rx_decode_end = 1'b1;
            rx_crc_ok = 1'($urandom);
            rx_payload_length = 7'($urandom);
        end
        @(posedge clk); #1;
        rx_decode_end = 1'b0;
        drop_exp = 255;
        @(negedge clk);
        total_cnt++; if (drop_count !== 8'hFF) $display("FAIL drop_sat: got %h want ff", drop_count); else pass_cnt++;
        total_cnt++; if (m_valid !== 1'b1 || m_data !== exp_q[0] || busy !== 1'b1) $display("FAIL drop_hold: valid %b data %h busy %b want 1 %h 1", m_valid, m_data, busy, exp_q[0]); else pass_cnt++;
        got_q.delete(); last_q.delete();
        m_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                last_q.push_back(m_last);
                if (m_last) break;
            end
            @(negedge clk);
        end
        total_cnt++; if (frame_errs() !== 0) $display("FAIL drop_sat_frame: %0d errors want 0", frame_errs()); else pass_cnt++;
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        int lasts = 0;
        fill_mem(1'b0);
        run_frame(1'b1, 30, 0, -1, 6);
        foreach (last_q[i]) if (last_q[i]) lasts++;
        total_cnt++; if (got_q.size() !== 5 || lasts !== 0) $display("FAIL rm_partial: got %0d octets %0d lasts want 5 0", got_q.size(), lasts); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b1; rx_decode_end = 1'b0; m_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        drop_exp = 0;
        total_cnt++; if (m_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rm_clear: valid %b busy %b want 0 0", m_valid, busy); else pass_cnt++;
        total_cnt++; if (addr !== 6'd0 || drop_count !== 8'd0) $display("FAIL rm_state: addr %0d drop %0d want 0 0", addr, drop_count); else pass_cnt++;
        fill_mem(1'b0);
        build_exp(1'b1, 40);
        run_frame(1'b1, 40, 0, -1, 200);
        total_cnt++; if (frame_errs() !== 0 || timed_out) $display("FAIL rm_fresh: %0d errors want 0", frame_errs()); else pass_cnt++;
        total_cnt++; if (timing_errs() !== 0) $display("FAIL rm_timing: %0d late octets want 0", timing_errs()); else pass_cnt++;
        idle_cycle();
    endtask

    initial begin
        fill_mem(1'b1);
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_truncation();
        test_back_to_back();
        test_crc_bad();
        test_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
